button_bounce_gen: RTL and testbench

Stimulus source that emulates a mechanical push button: on command it drives a single output through a pseudo-random burst of glitches and then holds the requested level for a settle window. It sits on the opposite side of the push-button debouncer in the SPI flash simulator. It exercises the debouncer in hardware and drives clean-press scenarios without a physical switch.

---
 rtl/button_bounce_gen_if.sv | 11 +
 rtl/button_bounce_gen.sv | 116 +++++++++++
 tb/tb_button_bounce_gen.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/button_bounce_gen_if.sv
// Request/status bundle between a button-bounce stimulus source and its user.
interface button_bounce_gen_if;
    logic start;
    logic level;
    logic noisy;
    logic busy;
    logic done;

    modport master (output start, output level, input noisy, input busy, input done);
    modport slave  (input start, input level, output noisy, output busy, output done);
endinterface

// File: rtl/button_bounce_gen.sv
// Mechanical push-button emulator: a pseudo-random glitch burst followed by a
// stable settle window at the requested level, then a one-cycle done pulse.
module button_bounce_gen #(
    parameter int          NBOUNCE   = 65000,
    parameter int          NSETTLE   = 650000,
    parameter int          NBITS     = 20,
    parameter int          HOLD_BITS = 8,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst_n,
    button_bounce_gen_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE} state_t;

    localparam logic [NBITS-1:0]   WIN_LAST = NBITS'(NBOUNCE - 1);
    localparam logic [NBITS-1:0]   SET_LAST = NBITS'(NSETTLE - 1);
    localparam logic [NBITS-1:0]   CNT_ONE  = 1;
    localparam logic [HOLD_BITS:0] SEG_ONE  = 1;
    // Galois taps for x^16+x^14+x^13+x^11+1 in a right-shifting register
    localparam logic [15:0]        TAPS     = 16'hB400;

    state_t               state, state_d;
    logic [15:0]          lfsr, lfsr_d;
    logic [NBITS-1:0]     window, window_d;
    logic [NBITS-1:0]     settle, settle_d;
    logic [HOLD_BITS:0]   segment, segment_d;
    logic [HOLD_BITS:0]   seg_load;
    logic                 noisy, noisy_d;
    logic                 busy, busy_d;
    logic                 done, done_d;
    logic                 lvl, lvl_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lfsr    <= SEED;
            window  <= '0;
            settle  <= '0;
            segment <= '0;
            noisy   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            lvl     <= 1'b0;
        end else begin
            state   <= state_d;
            lfsr    <= lfsr_d;
            window  <= window_d;
            settle  <= settle_d;
            segment <= segment_d;
            noisy   <= noisy_d;
            busy    <= busy_d;
            done    <= done_d;
            lvl     <= lvl_d;
        end
    end

    // Segment length 1..2^HOLD_BITS, so back-to-back toggles are possible
    assign seg_load = {1'b0, lfsr[HOLD_BITS-1:0]} + SEG_ONE;

    always_comb begin
        lfsr_d    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);
        state_d   = state;
        window_d  = window;
        settle_d  = settle;
        segment_d = segment;
        noisy_d   = noisy;
        busy_d    = busy;
        done_d    = 1'b0;
        lvl_d     = lvl;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.level != noisy) begin
                        state_d   = BOUNCE;
                        lvl_d     = bus.level;
                        noisy_d   = ~noisy;
                        busy_d    = 1'b1;
                        window_d  = '0;
                        segment_d = seg_load;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            BOUNCE: begin
                window_d = window + CNT_ONE;
                // End of the glitch window wins over a coincident toggle
                if (window == WIN_LAST) begin
                    noisy_d  = lvl;
                    settle_d = '0;
                    state_d  = SETTLE;
                end else if (segment == SEG_ONE) begin
                    noisy_d   = ~noisy;
                    segment_d = seg_load;
                end else begin
                    segment_d = segment - SEG_ONE;
                end
            end
            SETTLE: begin
                noisy_d  = lvl;
                settle_d = settle + CNT_ONE;
                if (settle == SET_LAST) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.noisy = noisy;
    assign bus.busy  = busy;
    assign bus.done  = done;
endmodule

// File: tb/tb_button_bounce_gen.sv
// Randomized bench for button_bounce_gen: expected traces are built from the
// toggle-event schedule, plus a behavioural debouncer on the noisy output.
module tb_button_bounce_gen;
    localparam int          NB     = 16;
    localparam int          NS     = 8;
    localparam int          HB     = 2;
    localparam int          DB_DLY = 12;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    button_bounce_gen_if bif();

    button_bounce_gen #(
        .NBOUNCE(NB), .NSETTLE(NS), .NBITS(20), .HOLD_BITS(HB), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bif)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Reference LFSR: value held during each cycle since reset
    logic [15:0] m_lfsr;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lstep(m_lfsr);

    // Debouncer model: output follows input after DB_DLY stable cycles
    logic db_clean, db_last;
    int   db_cnt;
    int   db_chg = 0;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            db_clean <= 1'b0; db_last <= 1'b0; db_cnt <= 0;
        end else if (bif.noisy != db_last) begin
            db_last <= bif.noisy; db_cnt <= 0;
        end else if (db_cnt < DB_DLY - 1) begin
            db_cnt <= db_cnt + 1;
        end else if (db_clean != db_last) begin
            db_clean <= db_last; db_chg <= db_chg + 1;
        end

    logic exp_noisy = 1'b0;
    logic trace[$];
    logic t1[$];
    logic t2[$];

    // All tasks are entered and left right after a falling clock edge
    task automatic do_reset(input int cyc);
        rst_n = 1'b0; bif.start = 1'b0; bif.level = 1'b0;
        repeat (cyc) @(negedge clk);
        chk("rst_noisy", bif.noisy, 0);
        chk("rst_busy",  bif.busy,  0);
        chk("rst_done",  bif.done,  0);
        rst_n = 1'b1;
        exp_noisy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("idle_noisy", bif.noisy, exp_noisy);
            chk("idle_busy",  bif.busy,  0);
            chk("idle_done",  bif.done,  0);
        end
    endtask

    // Full press toward lvl; inj>0 pulses an opposite-level start at T+inj
    task automatic press(input logic lvl, input int inj);
        logic        exp_n [1:NB+NS+1];
        logic [15:0] lf;
        logic        cur, prev, db0;
        int          nxt, chg0, tog;
        bif.start = 1'b1; bif.level = lvl;
        lf = m_lfsr; db0 = db_clean; chg0 = db_chg;
        cur = ~lvl; nxt = 0;
        for (int j = 0; j < NB; j++) begin
            if (j == nxt) begin
                cur = ~cur;
                nxt = j + int'(lf[HB-1:0]) + 1;
            end
            exp_n[j+1] = cur;
            lf = lstep(lf);
        end
        for (int k = NB + 1; k <= NB + NS + 1; k++) exp_n[k] = lvl;
        @(negedge clk);
        bif.start = 1'b0;
        tog = 0; prev = ~lvl;
        for (int k = 1; k <= NB + NS + 1; k++) begin
            chk("noisy", bif.noisy, exp_n[k]);
            chk("busy",  bif.busy,  k <= NB + NS);
            chk("done",  bif.done,  k == NB + NS + 1);
            if (k <= NB) chk("db_in_window", db_clean, db0);
            if (k > 1 && k <= NB && bif.noisy != prev) tog++;
            prev = bif.noisy;
            trace.push_back(bif.noisy);
            if (k == inj) begin bif.start = 1'b1; bif.level = ~lvl; end
            else bif.start = 1'b0;
            if (k < NB + NS + 1) @(negedge clk);
        end
        chk("glitch_seen", tog > 0, 1);
        exp_noisy = lvl;
        idle(DB_DLY + 2);
        chk("db_clean", db_clean, lvl);
        chk("db_changes", db_chg - chg0, 1);
    endtask

    task automatic same_req();
        bif.start = 1'b1; bif.level = exp_noisy;
        @(negedge clk);
        bif.start = 1'b0;
        chk("same_done",  bif.done,  1);
        chk("same_busy",  bif.busy,  0);
        chk("same_noisy", bif.noisy, exp_noisy);
        idle(1);
    endtask

    // Press that is cut short by reset in cycle T+at
    task automatic press_abort(input int at);
        bif.start = 1'b1; bif.level = ~exp_noisy;
        @(negedge clk);
        bif.start = 1'b0;
        repeat (at - 1) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_noisy", bif.noisy, 0);
        chk("abort_busy",  bif.busy,  0);
        chk("abort_done",  bif.done,  0);
        repeat (3) begin
            @(negedge clk);
            chk("abort_hold_done", bif.done, 0);
            chk("abort_hold_busy", bif.busy, 0);
        end
        rst_n = 1'b1;
        exp_noisy = 1'b0;
    endtask

    initial begin
        int nmis, r;
        bif.start = 1'b0; bif.level = 1'b0;

        do_reset(3); idle(20);
        trace.delete(); press(1'b1, 0); t1 = trace;
        do_reset(3); idle(20);
        trace.delete(); press(1'b1, 0); t2 = trace;
        chk("repro_len", t2.size(), t1.size());
        nmis = 0;
        for (int i = 0; i < t1.size() && i < t2.size(); i++)
            if (t1[i] !== t2[i]) nmis++;
        chk("repro_trace", nmis, 0);

        press(1'b0, 0);
        same_req();
        press(1'b1, 5);
        press(1'b0, 0);
        press(1'b1, 0);
        press_abort(8);
        idle(5);
        press(1'b1, 0);

        for (int it = 0; it < 40; it++) begin
            idle($urandom_range(0, 6));
            r = $urandom_range(0, 4);
            if (r == 0) same_req();
            else if (r == 1) press_abort($urandom_range(1, NB + NS));
            else press(~exp_noisy, ($urandom_range(0, 1) == 1) ? $urandom_range(1, NB + NS) : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
